bus_mem_ctrl: RTL and testbench

Data-side bus slave for the pipelined CPU: it services the CPU's level-held `bus_ren`/`bus_wen` load/store requests and returns a one-cycle `bus_done` with aligned read data. It decodes each request into an internal byte-maskable data RAM, an external MMIO port with a req/ack handshake and timeout, or an unmapped fault. It sits directly downstream of the CPU execute stage's load/store path.

---
 rtl/bus_mem_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_bus_mem_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_ctrl.sv
// Data-side bus slave: decodes CPU load/store requests into a byte-maskable RAM,
// an MMIO req/ack port with timeout, or an unmapped fault.
module bus_mem_ctrl #(
  parameter int unsigned MEM_SIZE_W   = 4096,
  parameter int unsigned MEM_WAIT     = 0,
  parameter logic [31:0] MMIO_BASE    = 32'h8000_0000,
  parameter int unsigned MMIO_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wmask,
  input  logic        bus_wen,
  input  logic        bus_ren,
  output logic [31:0] bus_rdata,
  output logic        bus_done,
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_wdata,
  output logic [3:0]  mmio_wmask,
  output logic        mmio_ren,
  output logic        mmio_wen,
  input  logic [31:0] mmio_rdata,
  input  logic        mmio_ack,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam int unsigned AW = $clog2(MEM_SIZE_W);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MEM_WAIT  = 2'd1,
    ST_MMIO_WAIT = 2'd2,
    ST_RESP      = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [2:0]  wait_cnt_r, wait_cnt_nxt_s;
  logic [7:0]  tmo_cnt_r, tmo_cnt_nxt_s;
  logic        wr_r, wr_nxt_s;
  logic [31:0] req_addr_r, req_addr_nxt_s;
  logic [31:0] req_wdata_r, req_wdata_nxt_s;
  logic [3:0]  req_wmask_r, req_wmask_nxt_s;
  logic        mmio_ren_r, mmio_ren_nxt_s;
  logic        mmio_wen_r, mmio_wen_nxt_s;
  logic        bus_done_r, bus_done_nxt_s;
  logic [31:0] bus_rdata_r, bus_rdata_nxt_s;
  logic        err_r, err_nxt_s;
  logic [31:0] err_addr_r, err_addr_nxt_s;

  logic        is_mem_s, is_mmio_s;
  logic        err_set_s;
  logic [31:0] fault_addr_s;
  logic        mem_we_s;
  logic [AW-1:0] idx_s;

  logic [31:0] mem_r [MEM_SIZE_W];

  assign is_mem_s  = ({2'b00, bus_addr[31:2]} < 32'(MEM_SIZE_W));
  assign is_mmio_s = (bus_addr >= MMIO_BASE);
  assign idx_s     = req_addr_r[AW+1:2];

  // Next-state and next-output computation for every registered signal
  always_comb begin
    state_nxt_s     = state_r;
    wait_cnt_nxt_s  = wait_cnt_r;
    tmo_cnt_nxt_s   = tmo_cnt_r;
    wr_nxt_s        = wr_r;
    req_addr_nxt_s  = req_addr_r;
    req_wdata_nxt_s = req_wdata_r;
    req_wmask_nxt_s = req_wmask_r;
    mmio_ren_nxt_s  = 1'b0;
    mmio_wen_nxt_s  = 1'b0;
    bus_done_nxt_s  = 1'b0;
    bus_rdata_nxt_s = bus_rdata_r;
    err_set_s       = 1'b0;
    fault_addr_s    = req_addr_r;
    mem_we_s        = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus_ren || bus_wen) begin
          req_addr_nxt_s  = bus_addr;
          req_wdata_nxt_s = bus_wdata;
          req_wmask_nxt_s = bus_wmask;
          wr_nxt_s        = bus_wen;
          if (bus_ren && bus_wen) begin
            err_set_s    = 1'b1;
            fault_addr_s = bus_addr;
          end else begin
            err_set_s    = 1'b0;
          end
          if (is_mem_s) begin
            state_nxt_s    = ST_MEM_WAIT;
            wait_cnt_nxt_s = 3'(MEM_WAIT);
          end else if (is_mmio_s) begin
            state_nxt_s    = ST_MMIO_WAIT;
            tmo_cnt_nxt_s  = 8'd0;
            mmio_ren_nxt_s = ~bus_wen;
            mmio_wen_nxt_s = bus_wen;
          end else begin
            state_nxt_s     = ST_RESP;
            bus_done_nxt_s  = 1'b1;
            bus_rdata_nxt_s = 32'd0;
            err_set_s       = 1'b1;
            fault_addr_s    = bus_addr;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MEM_WAIT: begin
        if (wait_cnt_r != 3'd0) begin
          wait_cnt_nxt_s = wait_cnt_r - 3'd1;
        end else begin
          mem_we_s        = wr_r;
          state_nxt_s     = ST_RESP;
          bus_done_nxt_s  = 1'b1;
          bus_rdata_nxt_s = wr_r ? 32'd0 : mem_r[idx_s];
        end
      end
      ST_MMIO_WAIT: begin
        if (mmio_ack) begin
          state_nxt_s     = ST_RESP;
          bus_done_nxt_s  = 1'b1;
          bus_rdata_nxt_s = wr_r ? 32'd0 : mmio_rdata;
        end else if ((tmo_cnt_r + 8'd1) == 8'(MMIO_TIMEOUT)) begin
          state_nxt_s     = ST_RESP;
          bus_done_nxt_s  = 1'b1;
          bus_rdata_nxt_s = 32'd0;
          err_set_s       = 1'b1;
          fault_addr_s    = req_addr_r;
        end else begin
          tmo_cnt_nxt_s  = tmo_cnt_r + 8'd1;
          mmio_ren_nxt_s = ~wr_r;
          mmio_wen_nxt_s = wr_r;
        end
      end
      ST_RESP: begin
        // Always return to IDLE so a held level request is not serviced twice
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    err_nxt_s = err_r | err_set_s;
    if (err_set_s && !err_r) begin
      err_addr_nxt_s = fault_addr_s;
    end else begin
      err_addr_nxt_s = err_addr_r;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= 3'd0;
      tmo_cnt_r   <= 8'd0;
      wr_r        <= 1'b0;
      req_addr_r  <= 32'd0;
      req_wdata_r <= 32'd0;
      req_wmask_r <= 4'd0;
      mmio_ren_r  <= 1'b0;
      mmio_wen_r  <= 1'b0;
      bus_done_r  <= 1'b0;
      bus_rdata_r <= 32'd0;
      err_r       <= 1'b0;
      err_addr_r  <= 32'd0;
    end else begin
      state_r     <= state_nxt_s;
      wait_cnt_r  <= wait_cnt_nxt_s;
      tmo_cnt_r   <= tmo_cnt_nxt_s;
      wr_r        <= wr_nxt_s;
      req_addr_r  <= req_addr_nxt_s;
      req_wdata_r <= req_wdata_nxt_s;
      req_wmask_r <= req_wmask_nxt_s;
      mmio_ren_r  <= mmio_ren_nxt_s;
      mmio_wen_r  <= mmio_wen_nxt_s;
      bus_done_r  <= bus_done_nxt_s;
      bus_rdata_r <= bus_rdata_nxt_s;
      err_r       <= err_nxt_s;
      err_addr_r  <= err_addr_nxt_s;
    end
  end

  // Data RAM with per-lane writes; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (rst && mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wmask_r[b]) begin
          mem_r[idx_s][8*b +: 8] <= req_wdata_r[8*b +: 8];
        end
      end
    end
  end

  assign bus_rdata  = bus_rdata_r;
  assign bus_done   = bus_done_r;
  assign mmio_addr  = req_addr_r;
  assign mmio_wdata = req_wdata_r;
  assign mmio_wmask = req_wmask_r;
  assign mmio_ren   = mmio_ren_r;
  assign mmio_wen   = mmio_wen_r;
  assign err        = err_r;
  assign err_addr   = err_addr_r;

endmodule

// File: tb/tb_bus_mem_ctrl.sv
// Self-checking bench for bus_mem_ctrl: table-driven RAM vectors plus directed
// sequences for held requests, MMIO ack/timeout, unmapped faults and mid-access reset.
module tb_bus_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] bus_addr = 32'd0, bus_wdata = 32'd0;
  logic [3:0]  bus_wmask = 4'd0;
  logic        bus_wen = 1'b0, bus_ren = 1'b0;
  logic [31:0] bus_rdata;
  logic        bus_done;
  logic [31:0] mmio_addr, mmio_wdata;
  logic [3:0]  mmio_wmask;
  logic        mmio_ren, mmio_wen;
  logic [31:0] mmio_rdata = 32'd0;
  logic        mmio_ack = 1'b0;
  logic        err;
  logic [31:0] err_addr;

  logic        d5_rst = 1'b0;
  logic [31:0] d5_addr = 32'd0, d5_wdata = 32'd0;
  logic [3:0]  d5_wmask = 4'd0;
  logic        d5_wen = 1'b0, d5_ren = 1'b0;
  logic [31:0] d5_rdata;
  logic        d5_done;
  logic [31:0] d5_mmio_addr, d5_mmio_wdata;
  logic [3:0]  d5_mmio_wmask;
  logic        d5_mmio_ren, d5_mmio_wen;
  logic [31:0] d5_mmio_rdata = 32'd0;
  logic        d5_mmio_ack = 1'b0;
  logic        d5_err;
  logic [31:0] d5_err_addr;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bus_mem_ctrl u_dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wmask(bus_wmask), .bus_wen(bus_wen), .bus_ren(bus_ren),
    .bus_rdata(bus_rdata), .bus_done(bus_done), .mmio_addr(mmio_addr),
    .mmio_wdata(mmio_wdata), .mmio_wmask(mmio_wmask), .mmio_ren(mmio_ren),
    .mmio_wen(mmio_wen), .mmio_rdata(mmio_rdata), .mmio_ack(mmio_ack),
    .err(err), .err_addr(err_addr)
  );

  bus_mem_ctrl #(.MEM_WAIT(5)) u_dut5 (
    .clk(clk), .rst(d5_rst), .bus_addr(d5_addr), .bus_wdata(d5_wdata),
    .bus_wmask(d5_wmask), .bus_wen(d5_wen), .bus_ren(d5_ren),
    .bus_rdata(d5_rdata), .bus_done(d5_done), .mmio_addr(d5_mmio_addr),
    .mmio_wdata(d5_mmio_wdata), .mmio_wmask(d5_mmio_wmask), .mmio_ren(d5_mmio_ren),
    .mmio_wen(d5_mmio_wen), .mmio_rdata(d5_mmio_rdata), .mmio_ack(d5_mmio_ack),
    .err(d5_err), .err_addr(d5_err_addr)
  );

  typedef struct {
    logic        wen;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // One request on the MEM_WAIT=5 instance; latency counted in cycles after acceptance
  task automatic op5(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m, input logic [31:0] exp_rd, input int exp_lat,
                     input string nm);
    int lat;
    logic [31:0] rd;
    lat = 99;
    rd  = 32'hxxxx_xxxx;
    d5_wen = w; d5_ren = r; d5_addr = a; d5_wdata = d; d5_wmask = m;
    for (int c = 1; c <= 40 && lat == 99; c++) begin
      @(negedge clk);
      if (d5_done) begin
        lat = c;
        rd  = d5_rdata;
      end
    end
    d5_wen = 1'b0; d5_ren = 1'b0;
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_rdata"}, rd, exp_rd);
    @(negedge clk);
  endtask

  initial begin
    int lat, dcnt, pos1, pos2, scnt;
    logic [31:0] rd;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'hAABB_CCDD, 4'b1111, 32'h0000_0000, 2};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'hAABB_CCDD, 2};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0012, 32'h1111_1111, 4'b0100, 32'h0000_0000, 2};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'hAA11_CCDD, 2};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_3FFC, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, 2};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_3FFF, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF, 2};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0014, 32'h0102_0304, 4'b1111, 32'h0000_0000, 2};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0014, 32'hFFFF_FFFF, 4'b0011, 32'h0000_0000, 2};

    repeat (3) @(negedge clk);
    chk("rst_done", {31'd0, bus_done}, 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    chk("rst_strobes", {30'd0, mmio_ren, mmio_wen}, 32'd0);
    chk("rst_mmio_addr", mmio_addr, 32'd0);
    rst = 1'b1;
    d5_rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      bus_wen = vecs[i].wen; bus_ren = vecs[i].ren; bus_addr = vecs[i].addr;
      bus_wdata = vecs[i].wdata; bus_wmask = vecs[i].mask;
      lat = 99;
      rd  = 32'hxxxx_xxxx;
      for (int c = 1; c <= 40 && lat == 99; c++) begin
        @(negedge clk);
        if (bus_done) begin
          lat = c;
          rd  = bus_rdata;
        end
      end
      bus_wen = 1'b0; bus_ren = 1'b0;
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'd0, err}, 32'd0);
      @(negedge clk);
    end

    // Load held high across two addresses: exactly two pulses, three cycles apart
    bus_ren = 1'b1; bus_addr = 32'h0000_0010;
    dcnt = 0; pos1 = 0; pos2 = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (bus_done) begin
        dcnt++;
        if (dcnt == 1) begin
          pos1 = c;
          chk("held_rd1", bus_rdata, 32'hAA11_CCDD);
        end else begin
          pos2 = c;
          chk("held_rd2", bus_rdata, 32'h0102_FFFF);
        end
      end
      if (c == 2) bus_addr = 32'h0000_0014;
      if (c == 5) bus_ren = 1'b0;
    end
    chk("held_cnt", 32'(dcnt), 32'd2);
    chk("held_pos1", 32'(pos1), 32'd2);
    chk("held_pos2", 32'(pos2), 32'd5);

    // MMIO read, ack presented in the fourth strobe cycle
    bus_ren = 1'b1; bus_addr = 32'h8000_0004;
    dcnt = 0; pos1 = 0; scnt = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) chk("mmio_addr", mmio_addr, 32'h8000_0004);
      if (mmio_ren) scnt++;
      if (bus_done) begin
        dcnt++;
        pos1 = c;
        chk("mmio_rdata", bus_rdata, 32'h1234_5678);
      end
      if (c == 4) begin
        mmio_ack = 1'b1; mmio_rdata = 32'h1234_5678;
      end
      if (c == 5) begin
        mmio_ack = 1'b0; mmio_rdata = 32'd0; bus_ren = 1'b0;
      end
    end
    chk("mmio_ren_cycles", 32'(scnt), 32'd4);
    chk("mmio_done_pos", 32'(pos1), 32'd5);
    chk("mmio_done_cnt", 32'(dcnt), 32'd1);
    chk("mmio_err", {31'd0, err}, 32'd0);

    // MMIO write with no ack runs into the timeout
    bus_wen = 1'b1; bus_addr = 32'h8000_0000; bus_wdata = 32'h5555_AAAA; bus_wmask = 4'b1111;
    dcnt = 0; pos1 = 0; scnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mmio_wen) scnt++;
      if (bus_done) begin
        dcnt++;
        pos1 = c;
        bus_wen = 1'b0;
      end
    end
    bus_wen = 1'b0;
    chk("tmo_done_pos", 32'(pos1), 32'd16);
    chk("tmo_done_cnt", 32'(dcnt), 32'd1);
    chk("tmo_wen_cycles", 32'(scnt), 32'd15);
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_err_addr", err_addr, 32'h8000_0000);

    // Unmapped read faults in one cycle; first fault address is kept
    bus_ren = 1'b1; bus_addr = 32'h4000_0000;
    pos1 = 0;
    for (int c = 1; c <= 4 && pos1 == 0; c++) begin
      @(negedge clk);
      if (bus_done) begin
        pos1 = c;
        chk("unmap_rdata", bus_rdata, 32'd0);
      end
    end
    bus_ren = 1'b0;
    chk("unmap_done_pos", 32'(pos1), 32'd1);
    chk("unmap_err", {31'd0, err}, 32'd1);
    chk("unmap_err_addr", err_addr, 32'h8000_0000);
    @(negedge clk);

    // MEM_WAIT=5 instance: latency, then reset during the wait phase
    op5(1'b1, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 4'b1111, 32'h0000_0000, 7, "w5_wr");
    op5(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, 4'b0000, 32'hCAFE_F00D, 7, "w5_rd");
    d5_ren = 1'b1; d5_addr = 32'h0000_0020;
    dcnt = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (d5_done) dcnt++;
    end
    d5_rst = 1'b0; d5_ren = 1'b0;
    @(negedge clk);
    if (d5_done) dcnt++;
    chk("w5_rst_rdata", d5_rdata, 32'd0);
    chk("w5_rst_err", {31'd0, d5_err}, 32'd0);
    d5_rst = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (d5_done) dcnt++;
    end
    chk("w5_rst_no_done", 32'(dcnt), 32'd0);
    op5(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, 4'b0000, 32'hCAFE_F00D, 7, "w5_rd_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
